// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one signed multiplier among N_REQ
// requesters. A granted request is issued with a one-cycle start, the
// multiplier's done is awaited under a watchdog, and the product (or an
// error on timeout) is returned with the requester ID over valid/ready.
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_abort,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     rsp_error,
  output logic                     busy,
  output logic [15:0]              txn_count
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                     state_q, state_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic signed [WIDTH-1:0]    mul_a_q, mul_a_d;
  logic signed [WIDTH-1:0]    mul_b_q, mul_b_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic signed [2*WIDTH-1:0]  result_q, result_d;
  logic                       error_q, error_d;
  logic [15:0]                txn_q, txn_d;

  logic                       grant_found;
  logic [ID_W-1:0]            grant_idx;
  logic [WIDTH-1:0]           grant_a;
  logic [WIDTH-1:0]           grant_b;
  int                         idx;

  // Round-robin search starting just after the last served requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
        grant_a     = req_a[idx*WIDTH +: WIDTH];
        grant_b     = req_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    id_d      = id_q;
    result_d  = result_q;
    error_d   = error_q;
    txn_d     = txn_q;
    req_ready = '0;
    mul_start = 1'b0;
    mul_abort = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // reset gating keeps every output quiet while reset is held
        if (grant_found && reset) begin
          req_ready[grant_idx] = 1'b1;
          mul_a_d = grant_a;
          mul_b_d = grant_b;
          id_d    = grant_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // a done arriving here belongs to nothing we started; ignore it
        mul_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (mul_done) begin
          // done takes priority over a simultaneous timeout
          result_d = mul_result;
          error_d  = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          mul_abort = 1'b1;
          result_d  = '0;
          error_d   = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rr_ptr_d = id_q;
          txn_d    = txn_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PTR_RST;
      timer_q  <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      id_q     <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      id_q     <= id_d;
      result_q <= result_d;
      error_q  <= error_d;
      txn_q    <= txn_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_error  = error_q;
  assign busy       = (state_q != S_IDLE);
  assign txn_count  = txn_q;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed shift-add multiplier datapath (with its control unit) among N_REQ requesters.
- Arbitrates round-robin between requesters and issues a one-cycle start to the multiplier.
- Waits for the multiplier's done, with a watchdog timeout, then returns the product tagged with the requester ID over a valid/ready response channel.
- Sits between the requesting blocks and the multiplier's start/done interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits; the product is 2*WIDTH.
- TIMEOUT, 64, maximum WAIT cycles before the operation is aborted (must be at least 2).
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*WIDTH  signed multiplicand; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  signed multiplier, packed the same way as req_a.
- req_ready  out  N_REQ  one-hot grant/accept.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_abort  out  1  one-cycle pulse on timeout; the multiplier returns to idle.
- mul_done  in  1  multiplier result valid (level or pulse).
- mul_result  in  2*WIDTH  signed product from the multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index of the response.
- rsp_result  out  2*WIDTH  product; 0 on error.
- rsp_error  out  1  1 = timeout abort.
- busy  out  1  high in any state other than IDLE.
- txn_count  out  16  count of completed responses; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=N_REQ-1, timer=0.
  - All outputs 0, including mul_a, mul_b, rsp_result, rsp_id and txn_count.
  - Takes effect immediately mid-operation. No response is produced for an in-flight request. mul_abort is not pulsed; the multiplier is reset separately.
- State IDLE:
  - The winner is the first i with req_valid[i]=1, searching (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready[winner]=1 combinationally. Only IDLE ever drives req_ready.
  - On the accept edge: latch operands into mul_a/mul_b, latch id, go to ISSUE.
  - No req_valid: stay in IDLE. req_valid may drop at any time without penalty.
- State ISSUE:
  - mul_start=1 for exactly this cycle. timer cleared. Next state WAIT.
  - A mul_done seen in ISSUE is ignored.
- mul_a and mul_b are held stable from ISSUE until WAIT exits.
- State WAIT (timer increments each cycle):
  - mul_done=1: capture mul_result into rsp_result, set rsp_error=0, go to RESP.
  - Otherwise, timer==TIMEOUT-1: pulse mul_abort for 1 cycle, set rsp_result=0 and rsp_error=1, go to RESP.
  - mul_done and timeout in the same cycle: done wins, with no abort and no error.
- State RESP:
  - rsp_valid=1 with rsp_id, rsp_result and rsp_error stable until rsp_ready=1.
  - On handshake: rr_ptr=id, txn_count+=1, go to IDLE.
  - A response completing with rsp_ready=1 on its first cycle takes one cycle.
- Latency:
  - Request accepted at edge T; mul_start high in cycle T+1.
  - mul_done sampled at edge D; rsp_valid high from cycle D+1.
  - Minimum back-to-back spacing per transaction is 4 cycles plus the multiply time.
- Fairness: a continuously requesting agent waits at most N_REQ-1 transactions.
- The result is passed through unmodified; sign handling is done by the multiplier datapath.

Test Plan:
- Single request: req_valid=4'b0001, a=-3, b=5; done after 12 cycles → rsp_id=0, rsp_result=16'hFFF1, rsp_error=0, txn_count=1.
- Round-robin: all 4 requesters held valid, with IDs encoded in the operands → responses in order 0,1,2,3,0; no requester is granted twice before the others.
- Timeout: mul_done never asserted, TIMEOUT=64 → mul_abort pulses in WAIT cycle 64, then rsp_error=1 and rsp_result=0; the next request is served normally.
- Backpressure: rsp_ready held 0 for 10 cycles → rsp_valid, id and result stay stable; req_ready stays 0 throughout; accept proceeds after rsp_ready=1.
- Race: mul_done asserted in the same cycle timer==TIMEOUT-1 → rsp_error=0, no mul_abort, correct product. Also mul_done during ISSUE is ignored.
- Reset: reset driven low during WAIT → all outputs 0 immediately, state IDLE, rr_ptr=N_REQ-1. After release, requester 0 wins a full contention.
